// File: rtl/sci_slave_port.sv
// Serial command-interface slave: deserialises write/read frames into one-cycle
// register-bank strobes and serialises read data back on the shared SCI_RESP/SCI_ACK lines.
module sci_slave_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  SCI_CSN,
  input  logic                  SCI_REQ,
  inout  logic                  SCI_RESP,
  inout  logic                  SCI_ACK,
  output logic                  REG_WREQ,
  output logic                  REG_RREQ,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  input  logic [DATA_WIDTH-1:0] REG_RDATA
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] LAST_A = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] LAST_D = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WACK, RFETCH, RLOAD, RDATA, DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  wnr;
  logic                  armed;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] wdata_sr;
  logic [DATA_WIDTH-1:0] rdata_sr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  drive;

  always_comb begin
    addr_next  = ADDR_WIDTH'({addr_sr, SCI_REQ});
    wdata_next = DATA_WIDTH'({wdata_sr, SCI_REQ});
  end

  // armed is only set by seeing CSN high, so a frame already in progress at
  // reset release (or CSN held low after WACK/DONE) cannot start a new frame.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      wnr       <= 1'b0;
      armed     <= 1'b0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_sr  <= '0;
      REG_WREQ  <= 1'b0;
      REG_RREQ  <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
    end else begin
      REG_WREQ <= 1'b0;
      REG_RREQ <= 1'b0;
      if (SCI_CSN) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (!SCI_CSN && armed) begin
            wnr   <= SCI_REQ;
            cnt   <= '0;
            armed <= 1'b0;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (SCI_CSN) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            addr_sr <= addr_next;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_A) begin
              cnt <= '0;
              if (wnr) begin
                state <= WDATA;
              end else begin
                state    <= RFETCH;
                REG_RREQ <= 1'b1;
                REG_ADDR <= addr_next;
              end
            end
          end
        end
        WDATA: begin
          if (SCI_CSN) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            wdata_sr <= wdata_next;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_D) begin
              cnt       <= '0;
              state     <= WACK;
              REG_WREQ  <= 1'b1;
              REG_ADDR  <= addr_sr;
              REG_WDATA <= wdata_next;
            end
          end
        end
        RFETCH: state <= SCI_CSN ? IDLE : RLOAD;
        RLOAD: begin
          if (SCI_CSN) begin
            state <= IDLE;
          end else begin
            rdata_sr <= REG_RDATA;
            cnt      <= '0;
            state    <= RDATA;
          end
        end
        RDATA: begin
          if (SCI_CSN) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            rdata_sr <= rdata_sr << 1;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_D) begin
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
        WACK, DONE: if (SCI_CSN) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line enable follows CSN combinationally so deselect releases the bus at once.
  assign drive    = !SCI_CSN && (state != IDLE);
  assign SCI_ACK  = drive ? ((state == WACK) || (state == RDATA)) : 1'bz;
  assign SCI_RESP = drive ? ((state == RDATA) && rdata_sr[DATA_WIDTH-1]) : 1'bz;

endmodule

// File: tb/tb_sci_slave_port.sv
// Bench for sci_slave_port: random and directed frames against a register-bank
// model; a scoreboard queue holds expected strobes, a monitor checks them.
module tb_sci_slave_port;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NBITS_W = 1 + AW + DW;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          csn = 1'b1;
  logic          req = 1'b0;
  wire           ack;
  wire           resp;
  logic          wreq, rreq;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;

  // Released lines read back as 1, so Z is distinguishable from a driven 0.
  pullup (ack);
  pullup (resp);

  sci_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCI_CSN(csn), .SCI_REQ(req),
    .SCI_RESP(resp), .SCI_ACK(ack),
    .REG_WREQ(wreq), .REG_RREQ(rreq), .REG_ADDR(addr),
    .REG_WDATA(wdata), .REG_RDATA(rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            is_write;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            partial;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] model[1 << AW];
  logic [DW-1:0] bank[1 << AW];
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Register bank: data is only meaningful the cycle after a read strobe.
  always @(posedge CLK) rdata <= rreq ? bank[addr] : DW'($urandom);

  initial begin
    txn_t t;
    forever begin
      @(negedge CLK);
      if (wreq || rreq) check("no_overlap", 32'(wreq & rreq), 0);
      if (wreq) begin
        bank[addr] = wdata;
        if (sb.size() == 0) check("unexpected_wreq", 1, 0);
        else begin
          t = sb.pop_front();
          check("wr_kind", 32'(t.is_write), 1);
          check("wr_addr", 32'(addr), 32'(t.a));
          check("wr_data", 32'(wdata), 32'(t.d));
          check("wr_ack", 32'(ack), 1);
        end
      end else if (rreq) begin
        if (sb.size() == 0) check("unexpected_rreq", 1, 0);
        else begin
          t = sb.pop_front();
          check("rd_kind", 32'(t.is_write), 0);
          check("rd_addr", 32'(addr), 32'(t.a));
          if (!t.partial) begin
            @(negedge CLK);
            check("rload_ack", 32'(ack), 0);
            for (int i = 0; i < DW; i++) begin
              @(negedge CLK);
              check("rdata_ack", 32'(ack), 1);
              check("rdata_bit", 32'(resp), 32'(t.d[DW-1-i]));
            end
            @(negedge CLK);
            check("done_ack", 32'(ack), 0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    csn = 1'b0;
    req = b;
    tick();
  endtask

  task automatic release_bus();
    csn = 1'b1;
    req = 1'($urandom);
    #1;
    check("release_ack_z", 32'(ack), 1);
    check("release_resp_z", 32'(resp), 1);
    tick();
  endtask

  task automatic idle(input int n);
    csn = 1'b1;
    for (int i = 0; i < n; i++) begin
      req = 1'($urandom);
      tick();
      check("idle_ack_z", 32'(ack), 1);
      check("idle_resp_z", 32'(resp), 1);
    end
  endtask

  // abort_at > 0: raise CSN after that many frame bits instead of finishing.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, input int abort_at);
    logic [AW+DW:0] f;
    int n;
    f = {1'b1, a, d};
    n = (abort_at > 0) ? abort_at : NBITS_W;
    if (abort_at == 0) begin
      sb.push_back('{1'b1, a, d, 1'b0});
      model[a] = d;
    end
    for (int i = 0; i < n; i++) begin
      send_bit(f[AW+DW-i]);
      if (i < NBITS_W - 1) begin
        check("wframe_ack_low", 32'(ack), 0);
        check("wframe_resp_low", 32'(resp), 0);
      end
    end
    if (abort_at == 0) begin
      for (int i = 0; i < hold; i++) begin
        send_bit(1'($urandom));
        check("wack_held", 32'(ack), 1);
      end
    end
    release_bus();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input int abort_at);
    logic [AW:0] f;
    f = {1'b0, a};
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) send_bit(f[AW-i]);
      release_bus();
    end else begin
      sb.push_back('{1'b0, a, model[a], 1'b0});
      for (int i = 0; i <= AW; i++) begin
        send_bit(f[AW-i]);
        check("rframe_ack_low", 32'(ack), 0);
      end
      for (int i = 0; i < DW + 3 + hold; i++) send_bit(1'($urandom));
      check("done_hold_ack", 32'(ack), 0);
      release_bus();
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int op;
    for (int i = 0; i < (1 << AW); i++) begin
      model[i] = DW'($urandom);
      bank[i]  = model[i];
    end
    model[3] = 8'hC3;
    bank[3]  = 8'hC3;

    repeat (3) tick();
    check("rst_wreq", 32'(wreq), 0);
    check("rst_rreq", 32'(rreq), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_ack_z", 32'(ack), 1);
    check("rst_resp_z", 32'(resp), 1);
    RSTN = 1'b1;
    idle(2);

    do_write(4'hA, 8'h5A, 3, 0);
    idle(1);
    do_read(4'h3, 0, 0);
    idle(2);

    do_write(4'h6, 8'h99, 0, 1 + AW + 5);
    idle(1);
    do_write(4'h6, 8'h3C, 1, 0);
    idle(1);

    idle(20);

    // Reset three bits into the read-data phase, CSN still low.
    sb.push_back('{1'b0, 4'h6, 8'h00, 1'b1});
    for (int i = 0; i <= AW; i++) send_bit((i == 0) ? 1'b0 : 1'(4'h6 >> (AW - i)));
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    RSTN = 1'b0;
    #1;
    check("rst_mid_ack_z", 32'(ack), 1);
    check("rst_mid_resp_z", 32'(resp), 1);
    check("rst_mid_addr", 32'(addr), 0);
    check("rst_mid_wdata", 32'(wdata), 0);
    tick();
    RSTN = 1'b1;
    for (int i = 0; i < NBITS_W + 2; i++) begin
      send_bit(1'b1);
      check("post_rst_no_frame", 32'(ack), 1);
    end
    idle(1);
    do_read(4'h6, 1, 0);
    idle(1);

    do_write(4'hF, 8'hFF, 0, 0);
    do_read(4'h0, 0, 0);
    idle(2);

    for (int k = 0; k < 40; k++) begin
      a  = AW'($urandom);
      d  = DW'($urandom);
      op = $urandom_range(0, 4);
      case (op)
        0, 1: do_write(a, d, $urandom_range(0, 3), 0);
        2:    do_write(a, d, 0, $urandom_range(1, NBITS_W - 1));
        3:    do_read(a, $urandom_range(0, 3), 0);
        default: do_read(a, 0, $urandom_range(1, AW));
      endcase
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
